// File: rtl/router_pkg.sv
// Shared router definitions: port indices, header field positions, default widths
// and the output-buffer state encoding used by the per-port allocation stage.
package router_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NUM_IN     = 5;
  localparam int PORT_IDX_W = 3;

  // Input index order is fixed: N,S,E,W,PE = 4..0
  localparam logic [PORT_IDX_W-1:0] P_N  = 3'd4;
  localparam logic [PORT_IDX_W-1:0] P_S  = 3'd3;
  localparam logic [PORT_IDX_W-1:0] P_E  = 3'd2;
  localparam logic [PORT_IDX_W-1:0] P_W  = 3'd1;
  localparam logic [PORT_IDX_W-1:0] P_PE = 3'd0;

  localparam int HDR_VC     = 63;
  localparam int HDR_DX     = 62;
  localparam int HDR_DY     = 61;
  localparam int HDR_RSV_HI = 60;
  localparam int HDR_RSV_LO = 56;
  localparam int HDR_HX_HI  = 55;
  localparam int HDR_HX_LO  = 52;
  localparam int HDR_HY_HI  = 51;
  localparam int HDR_HY_LO  = 48;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/out_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward (wrapping), returns a one-hot grant
// and the winner index; ptr moves just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int PTR_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  parameter int PTR_RST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt,
  output logic [PTR_W-1:0]  win,
  output logic              fire
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] scan_idx;
  logic             found;

  always_comb begin
    win      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NUM_IN);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign fire = en & (|req);

  // Grant is forced to zero unless enabled, so a blocked or idle port never pops an input
  always_comb begin
    gnt = '0;
    if (fire) gnt[win] = 1'b1;
  end

  assign ptr_nxt = (win == PTR_W'(NUM_IN - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_W'(PTR_RST);
    end else if (fire) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port allocation stage: round-robin grant, 5:1 packet mux and a one-entry
// output buffer drained by out_send/out_ready. Perf counters enabled by OUT_ARB_PERF_EN.
module out_port_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16,
  parameter int PTR_RST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        req,
  input  logic [DATA_W-1:0] pkt_n,
  input  logic [DATA_W-1:0] pkt_s,
  input  logic [DATA_W-1:0] pkt_e,
  input  logic [DATA_W-1:0] pkt_w,
  input  logic [DATA_W-1:0] pkt_pe,
  input  logic              out_ready,
  output logic [4:0]        gnt,
  output logic              out_send,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a packet moves downstream on every rising edge where out_send and
  // out_ready are both 1; out_send never drops until that transfer has happened.

  buf_state_t            state_q;
  buf_state_t            state_nxt;
  logic                  can_load;
  logic                  load;
  logic [PORT_IDX_W-1:0] win;
  logic [DATA_W-1:0]     mux_pkt;

  // Draining and reloading share one edge, so a full buffer with out_ready set is loadable
  assign can_load = (state_q == ST_EMPTY) | out_ready;

  rr_arbiter #(
    .NUM_IN  (NUM_IN),
    .PTR_W   (PORT_IDX_W),
    .PTR_RST (PTR_RST)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (can_load & rst_n),
    .gnt   (gnt),
    .win   (win),
    .fire  (load)
  );

  always_comb begin
    mux_pkt = pkt_pe;
    case (win)
      P_N:     mux_pkt = pkt_n;
      P_S:     mux_pkt = pkt_s;
      P_E:     mux_pkt = pkt_e;
      P_W:     mux_pkt = pkt_w;
      default: mux_pkt = pkt_pe;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !load) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= mux_pkt;
    end
  end

  assign out_send = (state_q == ST_FULL);

`ifdef OUT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_send && out_ready)  pkt_cnt   <= pkt_cnt + 1'b1;
      if (out_send && !out_ready) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign pkt_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed scenarios plus held-request random traffic,
// checked against a queue-based reference model and an output scoreboard.
module tb_out_port_arbiter;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [4:0]        req;
  logic [DATA_W-1:0] pkt_n, pkt_s, pkt_e, pkt_w, pkt_pe;
  logic              out_ready;
  logic [4:0]        gnt;
  logic              out_send;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  out_port_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .PTR_RST(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pkt_n     (pkt_n),
    .pkt_s     (pkt_s),
    .pkt_e     (pkt_e),
    .pkt_w     (pkt_w),
    .pkt_pe    (pkt_pe),
    .out_ready (out_ready),
    .gnt       (gnt),
    .out_send  (out_send),
    .out_data  (out_data),
    .pkt_cnt   (pkt_cnt),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // scoreboard and reference model state
  logic [DATA_W-1:0] exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                m_ptr;
  bit                m_full;
  logic [CNT_W-1:0]  m_pkt;
  logic [CNT_W-1:0]  m_stall;
  logic [4:0]        last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pkt_of(input int idx);
    case (idx)
      4:       return pkt_n;
      3:       return pkt_s;
      2:       return pkt_e;
      1:       return pkt_w;
      default: return pkt_pe;
    endcase
  endfunction

  // Round-robin rule: first requester found walking ptr, ptr+1, ... mod 5
  function automatic int rr_pick(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++) begin
      if (r[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_full  = 0;
    m_pkt   = '0;
    m_stall = '0;
    exp_q.delete();
  endtask

  // One cycle of the reference model, evaluated mid-cycle with inputs stable
  task automatic model_step();
    int         w;
    bit         can;
    logic [4:0] eg;
    check("out_send", 64'(out_send), 64'(m_full));
`ifdef OUT_ARB_PERF_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
    check("pkt_cnt_off", 64'(pkt_cnt), 64'd0);
    check("stall_cnt_off", 64'(stall_cnt), 64'd0);
`endif
    w   = rr_pick(req, m_ptr);
    can = !m_full || out_ready;
    eg  = (can && w >= 0) ? 5'(1 << w) : 5'd0;
    check("gnt", 64'(gnt), 64'(eg));
    last_gnt = gnt;
    if (m_full && out_ready)  m_pkt++;
    if (m_full && !out_ready) m_stall++;
    if (can) begin
      if (w >= 0) begin
        exp_q.push_back(pkt_of(w));
        m_ptr  = (w + 1) % 5;
        m_full = 1;
      end else begin
        m_full = 0;
      end
    end
  endtask

  // monitor: every transfer pops the oldest expected packet
  always @(negedge clk) begin
    if (rst_n && out_send && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'(out_data), 64'hx);
      end else begin
        check("sb_out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic rand_pkts();
    pkt_n  = {$urandom(), $urandom()};
    pkt_s  = {$urandom(), $urandom()};
    pkt_e  = {$urandom(), $urandom()};
    pkt_w  = {$urandom(), $urandom()};
    pkt_pe = {$urandom(), $urandom()};
  endtask

  task automatic drive(input logic [4:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_send", 64'(out_send), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    rst_n = 1'b1;
  endtask

  logic [4:0]        exp_seq[6];
  logic [DATA_W-1:0] held;
  logic [4:0]        pend;

  initial begin
    rand_pkts();
    do_reset();

    // directed: single east request, load, then drain to empty
    pkt_e = 64'h0010_0000_DEAD_BEEF;
    drive(5'b00100, 1'b1);
    check("t1_gnt", 64'(last_gnt), 64'h4);
    check("t1_out_send", 64'(out_send), 64'd1);
    check("t1_out_data", out_data, 64'h0010_0000_DEAD_BEEF);
    drive(5'b00000, 1'b1);
    drive(5'b00000, 1'b0);
    check("t1_empty", 64'(out_send), 64'd0);

    // directed: all requesting, grants rotate with no idle cycle
    do_reset();
    exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    for (int i = 0; i < 6; i++) begin
      rand_pkts();
      drive(5'b11111, 1'b1);
      check("t2_gnt_seq", 64'(last_gnt), 64'(exp_seq[i]));
    end

    // directed: stall holds data and blocks grants, then resumes
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      rand_pkts();
      drive(5'b01000, 1'b0);
      check("t3_stall_gnt", 64'(last_gnt), 64'd0);
      check("t3_hold_data", out_data, held);
    end
`ifdef OUT_ARB_PERF_EN
    check("t3_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    drive(5'b01000, 1'b1);
    check("t3_resume_gnt", 64'(last_gnt), 64'h8);

    // directed: ptr=2 with N and W requesting picks N
    rand_pkts();
    drive(5'b00010, 1'b1);
    rand_pkts();
    held = pkt_n;
    drive(5'b10010, 1'b1);
    check("t4_gnt", 64'(last_gnt), 64'h10);
    check("t4_out_data", out_data, held);

    // directed: reset while full, then pointer back at PTR_RST
    rand_pkts();
    drive(5'b00001, 1'b1);
    req = 5'b11111;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_out_send", 64'(out_send), 64'd0);
    check("t5_out_data", out_data, 64'd0);
    check("t5_gnt", 64'(gnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_pkts();
    drive(5'b00011, 1'b1);
    check("t5_first_gnt", 64'(last_gnt), 64'h1);

    // random traffic: requests held until granted, random backpressure
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      pend = pend | (5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)));
      rand_pkts();
      drive(pend, ($urandom_range(0, 3) != 0));
      pend = pend & ~last_gnt;
    end

    // drain
    drive(5'b00000, 1'b1);
    drive(5'b00000, 1'b1);
    check("drain_empty_q", 64'(exp_q.size()), 64'd0);
    check("drain_out_send", 64'(out_send), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
